npu_accum_drain: RTL and testbench

// - Output end of the weight-stationary systolic MAC array: takes the 32-bit accumulator stream leaving the bottom PE of each column.
// - Removes the one-cycle-per-column skew and requantizes each column to INT8 with scale/shift/round/zero-point/saturate.
// - Buffers result vectors in a FIFO and presents them on a valid/ready stream to the order/decision logic.
// - The array cannot stall, so this block never back-pressures its input.

---
 rtl/npu_accum_drain.sv | 174 +++++++++++++++++
 tb/tb_npu_accum_drain.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/npu_accum_drain.sv
// Drain end of the systolic MAC array: column deskew, INT8 requantization and a result-vector FIFO.
// Optional NPU_DRAIN_RELU_EN clamps negative shifted values to zero before the zero-point add.
`timescale 1ns/1ps
module npu_accum_drain #(
  parameter int N_COLS     = 4,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_COLS*ACC_W-1:0]         col_accum_in,
  input  logic [N_COLS-1:0]               col_valid_in,
  input  logic [15:0]                     cfg_mult,
  input  logic [4:0]                      cfg_shift,
  input  logic [7:0]                      cfg_zp,
  input  logic                            clr_flags,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_COLS*8-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            ovf_err,
  output logic                            skew_err,
  output logic                            sat_flag
);
  localparam int MULT_W = 17;
  localparam int PROD_W = ACC_W + MULT_W;
  localparam int EXT_W  = PROD_W + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int VEC_W  = N_COLS * 8;
  localparam logic signed [EXT_W-1:0] Q_MAX = 127;
  localparam logic signed [EXT_W-1:0] Q_MIN = -128;

  function automatic logic signed [EXT_W-1:0] rnd_shift(input logic signed [PROD_W-1:0] p,
                                                        input logic [4:0] sh);
    logic signed [EXT_W-1:0] bias;
    bias = '0;
    if (sh != 5'd0) bias = EXT_W'(1) << (sh - 5'd1);
    return (EXT_W'(p) + bias) >>> sh;
  endfunction

  function automatic logic is_sat(input logic signed [EXT_W-1:0] q);
    return (q > Q_MAX) || (q < Q_MIN);
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [EXT_W-1:0] q);
    if (q > Q_MAX)      return 8'h7f;
    else if (q < Q_MIN) return 8'h80;
    else                return q[7:0];
  endfunction

  // ---- deskew: lane j waits N_COLS-1-j cycles so all lanes line up with the last column
  logic signed [ACC_W-1:0] acc_al [N_COLS];
  logic [N_COLS-1:0]       vld_al;

  for (genvar j = 0; j < N_COLS; j++) begin : g_dsk
    localparam int D = N_COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign acc_al[j] = col_accum_in[j*ACC_W +: ACC_W];
      assign vld_al[j] = col_valid_in[j];
    end else begin : g_dly
      logic [ACC_W-1:0] acc_sr [D];
      logic [D-1:0]     vld_sr;
      always_ff @(posedge clk) begin
        acc_sr[0] <= col_accum_in[j*ACC_W +: ACC_W];
        for (int k = 1; k < D; k++) acc_sr[k] <= acc_sr[k-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= col_valid_in[j];
          for (int k = 1; k < D; k++) vld_sr[k] <= vld_sr[k-1];
        end
      end
      assign acc_al[j] = acc_sr[D-1];
      assign vld_al[j] = vld_sr[D-1];
    end
  end

  logic all_v, skew_hit;
  assign all_v    = &vld_al;
  assign skew_hit = (|vld_al) && !all_v;

  // ---- R1: scale by the unsigned multiplier; config is captured alongside the vector
  logic signed [MULT_W-1:0] mult_s;
  logic signed [PROD_W-1:0] prod_p1 [N_COLS];
  logic [4:0]               shift_p1;
  logic signed [7:0]        zp_p1;
  logic                     vld_p1;

  assign mult_s = $signed({1'b0, cfg_mult});

  always_ff @(posedge clk) begin
    for (int j = 0; j < N_COLS; j++) prod_p1[j] <= PROD_W'(acc_al[j]) * PROD_W'(mult_s);
    shift_p1 <= cfg_shift;
    zp_p1    <= $signed(cfg_zp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= all_v;
  end

  // ---- R2: round, shift, zero point, saturate
  logic [VEC_W-1:0] q_vec;
  logic             sat_any;
  logic [VEC_W-1:0] q_p2;
  logic             vld_p2;

  always_comb begin
    logic signed [EXT_W-1:0] r;
    logic signed [EXT_W-1:0] q;
    q_vec   = '0;
    sat_any = 1'b0;
    r       = '0;
    q       = '0;
    for (int j = 0; j < N_COLS; j++) begin
      r = rnd_shift(prod_p1[j], shift_p1);
`ifdef NPU_DRAIN_RELU_EN
      if (r[EXT_W-1]) r = '0;
`endif
      q = r + EXT_W'(zp_p1);
      q_vec[j*8 +: 8] = sat8(q);
      if (vld_p1 && is_sat(q)) sat_any = 1'b1;
    end
  end

  always_ff @(posedge clk) q_p2 <= q_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  // ---- result FIFO: extra pointer bit distinguishes full from empty
  logic [VEC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, pop, wr_en, drop;

  assign fifo_level = wr_ptr - rd_ptr;
  assign out_valid  = (wr_ptr != rd_ptr);
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop        = out_valid && out_ready;
  assign wr_en      = vld_p2 && (!full || pop);
  assign drop       = vld_p2 && full && !pop;
  assign out_data   = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= q_p2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err  <= 1'b0;
      skew_err <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      ovf_err  <= drop     ? 1'b1 : (clr_flags ? 1'b0 : ovf_err);
      skew_err <= skew_hit ? 1'b1 : (clr_flags ? 1'b0 : skew_err);
      sat_flag <= sat_any  ? 1'b1 : (clr_flags ? 1'b0 : sat_flag);
    end
  end
endmodule

// File: tb/tb_npu_accum_drain.sv
// Scoreboard bench for npu_accum_drain: directed skewed vectors, expected INT8 lanes queued at issue.
`timescale 1ns/1ps
module tb_npu_accum_drain;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] col_accum_in;
  logic [3:0]   col_valid_in;
  logic [15:0]  cfg_mult;
  logic [4:0]   cfg_shift;
  logic [7:0]   cfg_zp;
  logic         clr_flags;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [3:0]   fifo_level;
  logic         ovf_err, skew_err, sat_flag;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  npu_accum_drain #(.N_COLS(4), .ACC_W(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .col_accum_in(col_accum_in), .col_valid_in(col_valid_in),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .clr_flags(clr_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .ovf_err(ovf_err), .skew_err(skew_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int b0, input int b1, input int b2, input int b3);
    return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Column k is driven k cycles after column 0; returns just after column 3 is sampled.
  task automatic send(input int a0, input int a1, input int a2, input int a3,
                      input logic [3:0] m, input bit push, input logic [31:0] ex);
    int a[4];
    a = '{a0, a1, a2, a3};
    if (push) exp_q.push_back(ex);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      col_valid_in = '0;
      col_valid_in[k] = m[k];
      col_accum_in[k*32 +: 32] = a[k];
    end
    @(posedge clk); #1;
    col_valid_in = '0;
    col_accum_in = '0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  // Monitor: every accepted output beat is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; col_accum_in = '0; col_valid_in = '0;
    cfg_mult = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd0;
    clr_flags = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_flags", {ovf_err, skew_err, sat_flag}, 0);
    rst_n = 1'b1;
    idle(1);

    // pass-through and exact latency
    send(5, -3, 100, -50, 4'hf, 1, pk(5, -3, 100, -50));
    @(posedge clk); #1; chk("lat_early", out_valid, 0);
    @(posedge clk); #1; chk("lat_3", out_valid, 1);
    idle(2);

    // rounding and zero point
    cfg_shift = 5'd2;
    send(5, 6, -6, -7, 4'hf, 1, pk(1, 2, -1, -2));
    idle(4);
    cfg_mult = 16'd3; cfg_shift = 5'd1;
    send(7, 0, 1, -1, 4'hf, 1, pk(11, 0, 2, -1));
    idle(4);
    cfg_mult = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd10;
    send(0, -138, 117, -20, 4'hf, 1, pk(10, -128, 127, -10));
    idle(4);
    chk("sat_edge_none", sat_flag, 0);

    // saturation and flag clear
    cfg_zp = 8'd0;
    send(1000, -1000, 127, -128, 4'hf, 1, pk(127, -128, 127, -128));
    idle(4);
    chk("sat_set", sat_flag, 1);
    pulse_clr();
    chk("sat_clr", sat_flag, 0);

    // lane 2 withheld, then a clean vector
    send(1, 2, 3, 4, 4'b1011, 0, 0);
    idle(4);
    chk("skew_set", skew_err, 1);
    chk("skew_nowrite", fifo_level, 0);
    send(1, 2, 3, 4, 4'hf, 1, pk(1, 2, 3, 4));
    idle(4);
    pulse_clr();
    chk("skew_clr", skew_err, 0);

    // overflow with consumer stalled, then drain one per cycle
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(i, -i, 2*i, 3*i, 4'hf, i <= 8, pk(i, -i, 2*i, 3*i));
    idle(4);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_set", ovf_err, 1);
    chk("head_hold", out_data, pk(1, -1, 2, 3));
    idle(2);
    chk("head_stable", out_data, pk(1, -1, 2, 3));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("drain_level", fifo_level, 7 - k);
    end
    chk("drain_q", exp_q.size(), 0);

    // reset with three queued and one in flight
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(10*i, i, -i, 0, 4'hf, 1, pk(10*i, i, -i, 0));
    idle(4);
    chk("pre_rst_level", fifo_level, 3);
    send(9, 9, 9, 9, 4'hf, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_flags", {ovf_err, skew_err, sat_flag}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    chk("post_rst_level", fifo_level, 0);

    // negative shifted values under the optional clamp
    cfg_zp = 8'd5;
`ifdef NPU_DRAIN_RELU_EN
    send(-40, 3, -1, 0, 4'hf, 1, pk(5, 8, 5, 5));
`else
    send(-40, 3, -1, 0, 4'hf, 1, pk(-35, 8, 4, 5));
`endif
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("final_q", exp_q.size(), 0);
    chk("final_sat", sat_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
